// File: rtl/batchnorm_stream_if.sv
// Stream and parameter-load bundle for batchnorm_stream.
// The master side feeds samples and parameters and consumes results.
// The slave side is the normalisation unit itself.
interface batchnorm_stream_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 6
);
    logic             prm_we;
    logic [CW-1:0]    prm_addr;
    logic [WIDTH-1:0] prm_gamma;
    logic [WIDTH-1:0] prm_beta;

    logic [WIDTH-1:0] x_in;
    logic [CW-1:0]    channel_in;
    logic             valid_in;
    logic             in_ready;

    logic [WIDTH-1:0] y_out;
    logic [CW-1:0]    channel_out;
    logic             valid_out;
    logic             out_ready;
    logic             ch_err;

    modport master (
        output prm_we, prm_addr, prm_gamma, prm_beta,
        output x_in, channel_in, valid_in, out_ready,
        input  in_ready, y_out, channel_out, valid_out, ch_err
    );

    modport slave (
        input  prm_we, prm_addr, prm_gamma, prm_beta,
        input  x_in, channel_in, valid_in, out_ready,
        output in_ready, y_out, channel_out, valid_out, ch_err
    );
endinterface

// File: rtl/batchnorm_stream.sv
// Streaming per-channel batch normalisation with fused ReLU/ReLU6.
// y = act(sat(round(x*gamma[c]) + beta[c])), one element per cycle.
// Gamma/beta live in a runtime-loaded register file.
// Pipeline: S1 operand capture, S2 product, S3a round+bias sum,
// S3b saturate/activate into the output registers (3-cycle latency).
module batchnorm_stream #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int CHANNELS = 48,
    parameter int CW       = $clog2(CHANNELS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    batchnorm_stream_if.slave bus,
    output logic [15:0] sat_count
);
    localparam int PW = 2 * WIDTH;

    localparam logic signed [PW-1:0]    HALF_W = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [PW-1:0]    MAX_W  = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]    MIN_W  = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0]    SIX_W  = {{(PW-3){1'b0}}, 3'b110} << FRAC;
    localparam logic signed [PW-1:0]    CAP_W  = (SIX_W > MAX_W) ? MAX_W : SIX_W;
    localparam logic signed [WIDTH-1:0] MAX_N  = MAX_W[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] MIN_N  = MIN_W[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] CAP_N  = CAP_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0]        ONE_N  = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [CW:0]             CH_LIM = (CW+1)'(CHANNELS);

    // parameter file
    logic [WIDTH-1:0] gamma_r [CHANNELS];
    logic [WIDTH-1:0] beta_r  [CHANNELS];

    // handshake and read-port signals
    logic             adv_s;
    logic             rd_ok_s;
    logic             wr_ok_s;
    logic [WIDTH-1:0] g_rd_s;
    logic [WIDTH-1:0] b_rd_s;

    // S1
    logic             v1_r;
    logic             e1_r;
    logic [CW-1:0]    ch1_r;
    logic [WIDTH-1:0] x1_r;
    logic [WIDTH-1:0] g1_r;
    logic [WIDTH-1:0] b1_r;

    // S2
    logic                 v2_r;
    logic                 e2_r;
    logic [CW-1:0]        ch2_r;
    logic signed [PW-1:0] p2_r;
    logic [WIDTH-1:0]     b2_r;

    // S3a
    logic                 v3_r;
    logic                 e3_r;
    logic [CW-1:0]        ch3_r;
    logic signed [PW-1:0] sum3_r;

    // output registers
    logic             valid_out_r;
    logic             ch_err_r;
    logic [CW-1:0]    channel_out_r;
    logic [WIDTH-1:0] y_out_r;
    logic [15:0]      sat_count_r;

    // datapath combinational values
    logic signed [PW-1:0]    prod_s;
    logic signed [PW-1:0]    rnd_s;
    logic signed [PW-1:0]    bext_s;
    logic signed [PW-1:0]    sum_s;
    logic signed [WIDTH-1:0] clip_s;
    logic signed [WIDTH-1:0] act_s;
    logic                    sat_s;
    logic [WIDTH-1:0]        y_fin_s;
    logic                    sat_fin_s;

    assign adv_s   = en && (!valid_out_r || bus.out_ready);
    assign rd_ok_s = ({1'b0, bus.channel_in} < CH_LIM);
    assign wr_ok_s = bus.prm_we && ({1'b0, bus.prm_addr} < CH_LIM);

    assign bus.in_ready    = adv_s;
    assign bus.y_out       = y_out_r;
    assign bus.channel_out = channel_out_r;
    assign bus.valid_out   = valid_out_r;
    assign bus.ch_err      = ch_err_r;
    assign sat_count       = sat_count_r;

    // Parameter file: writes ignore en; out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                gamma_r[i] <= ONE_N;
                beta_r[i]  <= {WIDTH{1'b0}};
            end
        end else if (wr_ok_s) begin
            gamma_r[bus.prm_addr] <= bus.prm_gamma;
            beta_r[bus.prm_addr]  <= bus.prm_beta;
        end
    end

    // Parameter read for the incoming channel; invalid channels read as zero.
    always_comb begin
        g_rd_s = {WIDTH{1'b0}};
        b_rd_s = {WIDTH{1'b0}};
        if (rd_ok_s) begin
            g_rd_s = gamma_r[bus.channel_in];
            b_rd_s = beta_r[bus.channel_in];
        end else begin
            g_rd_s = {WIDTH{1'b0}};
            b_rd_s = {WIDTH{1'b0}};
        end
    end

    // Arithmetic: full-width product, round-half-up rescale, bias add.
    always_comb begin
        prod_s = PW'($signed(x1_r)) * PW'($signed(g1_r));
        rnd_s  = (p2_r + HALF_W) >>> FRAC;
        bext_s = PW'($signed(b2_r));
        sum_s  = rnd_s + bext_s;
    end

    // Saturation to the data range, then activation and channel-error override.
    always_comb begin
        sat_s  = 1'b0;
        clip_s = sum3_r[WIDTH-1:0];
        if (sum3_r > MAX_W) begin
            clip_s = MAX_N;
            sat_s  = 1'b1;
        end else if (sum3_r < MIN_W) begin
            clip_s = MIN_N;
            sat_s  = 1'b1;
        end else begin
            clip_s = sum3_r[WIDTH-1:0];
            sat_s  = 1'b0;
        end

        act_s = clip_s;
        case (mode)
            2'd1: begin
                if (clip_s < $signed({WIDTH{1'b0}})) begin
                    act_s = {WIDTH{1'b0}};
                end else begin
                    act_s = clip_s;
                end
            end
            2'd2: begin
                if (clip_s < $signed({WIDTH{1'b0}})) begin
                    act_s = {WIDTH{1'b0}};
                end else if (clip_s > CAP_N) begin
                    act_s = CAP_N;
                end else begin
                    act_s = clip_s;
                end
            end
            default: act_s = clip_s;
        endcase

        if (e3_r) begin
            y_fin_s   = {WIDTH{1'b0}};
            sat_fin_s = 1'b0;
        end else begin
            y_fin_s   = act_s;
            sat_fin_s = sat_s;
        end
    end

    // All stages shift together on adv; bubbles travel as cleared valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r          <= 1'b0;
            e1_r          <= 1'b0;
            ch1_r         <= {CW{1'b0}};
            x1_r          <= {WIDTH{1'b0}};
            g1_r          <= {WIDTH{1'b0}};
            b1_r          <= {WIDTH{1'b0}};
            v2_r          <= 1'b0;
            e2_r          <= 1'b0;
            ch2_r         <= {CW{1'b0}};
            p2_r          <= {PW{1'b0}};
            b2_r          <= {WIDTH{1'b0}};
            v3_r          <= 1'b0;
            e3_r          <= 1'b0;
            ch3_r         <= {CW{1'b0}};
            sum3_r        <= {PW{1'b0}};
            valid_out_r   <= 1'b0;
            ch_err_r      <= 1'b0;
            channel_out_r <= {CW{1'b0}};
            y_out_r       <= {WIDTH{1'b0}};
        end else if (adv_s) begin
            v1_r          <= bus.valid_in;
            e1_r          <= !rd_ok_s;
            ch1_r         <= bus.channel_in;
            x1_r          <= bus.x_in;
            g1_r          <= g_rd_s;
            b1_r          <= b_rd_s;
            v2_r          <= v1_r;
            e2_r          <= e1_r;
            ch2_r         <= ch1_r;
            p2_r          <= prod_s;
            b2_r          <= b1_r;
            v3_r          <= v2_r;
            e3_r          <= e2_r;
            ch3_r         <= ch2_r;
            sum3_r        <= sum_s;
            valid_out_r   <= v3_r;
            ch_err_r      <= v3_r && e3_r;
            channel_out_r <= ch3_r;
            y_out_r       <= y_fin_s;
        end
    end

    // Saturation event counter, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_r <= 16'd0;
        end else if (adv_s && v3_r && sat_fin_s && (sat_count_r != 16'hFFFF)) begin
            sat_count_r <= sat_count_r + 16'd1;
        end
    end
endmodule

// File: doc/batchnorm_stream.md
# batchnorm_stream

Streaming, parametrised per-channel batch-normalisation unit with fused activation, the successor to the fixed Q8.8 `batchnorm` used in the SHORTCUT and bottleneck paths. Computes y = act(sat(round(x·γ[c]) + β[c])) on a valid/ready stream. γ/β are held in an internal register file loaded at runtime, replacing the wide packed buses. Sits between the depthwise/pointwise conv outputs and the shortcut adder, with a throughput of one element per cycle under backpressure.

## Interface
- WIDTH, 16, signed fixed-point data/parameter width
- FRAC, 8, fractional bits of data, γ and β
- CHANNELS, 48, number of channels (≥2)
- CW, $clog2(CHANNELS), channel index width (derived)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; when low, the pipeline holds and in_ready=0
- mode  in  2  activation: 0 none, 1 ReLU, 2 ReLU6, 3 reserved (treated as 0)
- prm_we  in  1  parameter write strobe
- prm_addr  in  CW  channel being written
- prm_gamma  in  WIDTH  γ value (signed, FRAC fractional bits)
- prm_beta  in  WIDTH  β value
- x_in  in  WIDTH  input sample (signed)
- channel_in  in  CW  channel index of x_in
- valid_in  in  1  input valid
- in_ready  out  1  input ready
- y_out  out  WIDTH  result
- channel_out  out  CW  channel index aligned with y_out
- valid_out  out  1  output valid
- out_ready  in  1  downstream ready
- ch_err  out  1  asserted with valid_out when that element's channel ≥ CHANNELS
- sat_count  out  16  count of saturation events; saturates at 0xFFFF

## Operation
- Parameter file: CHANNELS entries of {γ, β}. Reset value is γ=1<<FRAC (1.0) and β=0. A write occurs when prm_we=1, independent of en. A prm_addr ≥ CHANNELS is ignored.
- Pipeline:
  - S1 registers x, the channel, γ[c] and β[c].
  - S2 registers the signed product p = x·γ (2·WIDTH bits).
  - S3 computes r = (p + (1<<(FRAC−1))) >>> FRAC (arithmetic shift, round-half-up). It then adds β sign-extended to 2·WIDTH and saturates to the signed WIDTH range [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Finally it applies the activation and registers the outputs.
- Activation, applied after saturation:
  - ReLU: negative values become 0.
  - ReLU6: the value is clamped to [0, min(6<<FRAC, max positive)].
- sat_count increments by 1 on each element leaving S3 whose pre-saturation sum was out of range. Activation clamping does not count.
- Out-of-range channel: the γ/β read uses 0 and y_out=0. channel_out carries the raw index and ch_err=1. The element does not count as saturated.
- Write/read hazard: if the same channel is written and read in S1 in the same cycle, S1 captures the old value. The new value applies from the next accepted element.
- mode is sampled in S3 and must be held stable while data is in flight.

## Timing
- Reset values: y_out=0, channel_out=0, valid_out=0, ch_err=0, sat_count=0, all stage valids 0, and the parameter file at its defaults.
- The pipeline advances when adv = en && (!valid_out || out_ready). All stages shift together.
- in_ready = adv, which is combinational from en, valid_out and out_ready.
- A handshake occurs when valid_in && in_ready. A beat accepted at edge N appears as valid_out after edge N+3 (3-cycle latency) when there are no stalls.
- Bubbles propagate: stage valids shift with adv, and empty stages do not block.
- Stall with out_ready=0 and valid_out=1: every stage holds and no data is dropped or duplicated. Throughput is 1 element/cycle with out_ready held at 1.
- en=0 freezes the pipeline, including valid_out. Parameter writes still take effect.
- Asserting rst mid-stream discards all in-flight data immediately (async). The parameter file returns to its defaults.

## Test plan
- Basic, mode 0: set ch5 γ=0x0180, β=0x0100, then send x=0x0200 on ch5. Required: y_out=0x0400 with channel_out=5, exactly 3 cycles after acceptance, and sat_count=0.
- Rounding and negatives: with γ=0x0080, x=0xFFFF gives (−1·128+128)>>>8 = 0, so y=0x0000. With x=0x0003, y=0x0002 (round-half-up of 1.5).
- Saturation: with γ=0x0400, x=0x7000 gives y=0x7FFF and x=0x9000 gives y=0x8000. sat_count=2.
- Activation: with γ=1.0 and β=0, x=0xFF00 in mode 1 gives 0x0000. x=0x0800 in mode 2 gives 0x0600. x=0x0300 in mode 2 gives 0x0300.
- Backpressure: stream 1000 random elements across 48 channels with out_ready toggled pseudo-randomly. Required: outputs match the reference model in order, there is no loss or duplication, and in_ready=0 whenever valid_out && !out_ready.
- Reset and defaults: load non-default params, assert rst while 3 elements are in flight. Required: valid_out drops to 0 immediately, and a following x=0x1234 on ch47 yields 0x1234 (γ=1, β=0). Also, channel_in=48 yields y_out=0 with ch_err=1.
